mdu_hilo: RTL

- Multi-cycle multiply/divide unit with the architectural HI/LO registers, alongside the single-cycle ALU in the EX stage of the 5-stage MIPS pipeline.
- Executes mult, multu, div, divu, mthi and mtlo; mfhi/mflo read the `hi_out`/`lo_out` outputs.
- Raises `busy` for a fixed latency. The hazard unit stalls any MDU instruction in ID while `start | busy`.

---
 rtl/mdu_hilo_pkg.sv | 23 ++
 rtl/mdu_hilo_if.sv | 21 ++
 rtl/mdu_hilo.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mdu_hilo_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes,
// default latencies and controller state encoding.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6
    } md_op_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_hilo_if.sv
// EX-stage to MDU connection: operands, op code, start pulse and the
// HI/LO/busy results read back by the pipeline.
interface mdu_hilo_if;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  mdctrl;
    logic        start;
    logic        busy;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    modport master (
        output a, b, mdctrl, start,
        input  busy, hi_out, lo_out
    );

    modport slave (
        input  a, b, mdctrl, start,
        output busy, hi_out, lo_out
    );
endinterface

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit with the architectural HI/LO registers.
// The 64-bit result is computed and held at the start edge; the down-counter
// only models the latency, and HI/LO are written when it reaches zero.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | accepting mult/div/mthi/mtlo, busy low
// ST_RUN  | counting down the latency, result held, busy high
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    mdu_hilo_if.slave   bus
);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] res_q, res_d;
    logic        wr_q, wr_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] abs_a, abs_b, div_b;
    logic [31:0] q_mag, r_mag, q_s, r_s;
    logic [31:0] divu_b, q_u, r_u;

    // Datapath: signed/unsigned products and quotient/remainder from the live operands.
    // Signed division runs on magnitudes so that 0x80000000 / -1 wraps cleanly.
    always_comb begin
        prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
        prod_u = {32'd0, bus.a} * {32'd0, bus.b};
        abs_a  = bus.a[31] ? (~bus.a + 32'd1) : bus.a;
        abs_b  = bus.b[31] ? (~bus.b + 32'd1) : bus.b;
        div_b  = (abs_b == 32'd0) ? 32'd1 : abs_b;
        q_mag  = abs_a / div_b;
        r_mag  = abs_a % div_b;
        q_s    = (bus.a[31] ^ bus.b[31]) ? (~q_mag + 32'd1) : q_mag;
        r_s    = bus.a[31] ? (~r_mag + 32'd1) : r_mag;
        divu_b = (bus.b == 32'd0) ? 32'd1 : bus.b;
        q_u    = bus.a / divu_b;
        r_u    = bus.a % divu_b;
    end

    // Next-state: op acceptance in IDLE, countdown and write-back in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        wr_d    = wr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.mdctrl)
                        MD_MULT: begin
                            res_d   = prod_s;
                            wr_d    = 1'b1;
                            cnt_d   = 4'(MULT_LAT - 1);
                            state_d = ST_RUN;
                        end
                        MD_MULTU: begin
                            res_d   = prod_u;
                            wr_d    = 1'b1;
                            cnt_d   = 4'(MULT_LAT - 1);
                            state_d = ST_RUN;
                        end
                        MD_DIV: begin
                            res_d   = {r_s, q_s};
                            wr_d    = (bus.b != 32'd0);
                            cnt_d   = 4'(DIV_LAT - 1);
                            state_d = ST_RUN;
                        end
                        MD_DIVU: begin
                            res_d   = {r_u, q_u};
                            wr_d    = (bus.b != 32'd0);
                            cnt_d   = 4'(DIV_LAT - 1);
                            state_d = ST_RUN;
                        end
                        MD_MTHI: hi_d = bus.a;
                        MD_MTLO: lo_d = bus.a;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    if (wr_q) begin
                        hi_d = res_q[63:32];
                        lo_d = res_q[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and HI/LO registers; reset clears everything and aborts a running op.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            res_q   <= 64'd0;
            wr_q    <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            wr_q    <= wr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy   = (state_q == ST_RUN);
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;

endmodule
